key_control: RTL
================

// Module: key_control
// PURPOSE
//  Consumes decoded keypad outputs (octave up/down, mode, goof, keycode, strobe) and turns them
//  into stable synth control state: saturating octave register, cycling mode, goof toggle, and a
//  latched note with one-cycle note_on/note_off pulses. Sits directly downstream of the keypad
//  encoder; feeds the oscillator/frequency-lookup stage.
// PARAMETERS
//  OCT_MAX      7   highest octave value; octave saturates in [0, OCT_MAX]
//  OCT_DEFAULT  4   octave value after reset
//  NUM_MODES    4   number of waveform modes; mode cycles 0..NUM_MODES-1
//  REL_CYCLES   16  consecutive no-note cycles required before a held note is released (>=1)
// PORTS
//  clk              in   1  system clock, all state on rising edge
//  n_rst            in   1  asynchronous active-low reset
//  octave_key_up    in   1  level, from keypad encoder
//  octave_key_down  in   1  level, from keypad encoder
//  mode_key         in   1  level, from keypad encoder
//  goof_key         in   1  level, from keypad encoder
//  keycode          in   5  note code from keypad encoder (valid only when note_press)
//  strobe           in   1  any key active
//  octave           out  3  current octave
//  mode             out  2  current waveform mode
//  goof_en          out  1  goof effect enable
//  note             out  5  latched keycode of sounding note
//  gate             out  1  high while a note is sounding
//  note_on          out  1  1-cycle pulse: new note latched (incl. retrigger)
//  note_off         out  1  1-cycle pulse: note released
// BEHAVIOUR
//  - Reset (n_rst=0, async): octave=OCT_DEFAULT, mode=0, goof_en=0, note=0, gate=0, note_on=0,
//    note_off=0, FSM=IDLE, release counter=0, edge-detect history regs=0. Reset mid-note drops
//    gate immediately with no note_off pulse.
//  - Edge detect: prev regs hold last-cycle level of the 4 control keys; rise = cur & ~prev.
//    Key held for many cycles acts once. All outputs registered: 1-cycle latency input->output.
//  - Octave: up-rise -> +1, saturate at OCT_MAX; down-rise -> -1, saturate at 0. Both rising the
//    same cycle -> no change. Octave changes while gate=1 are allowed; note stays latched.
//  - Mode: mode_key rise -> mode+1, NUM_MODES-1 wraps to 0. goof_key rise -> goof_en toggles.
//  - note_press = strobe & ~(octave_key_up|octave_key_down|mode_key|goof_key). keycode 0 is a
//    valid note when note_press=1.
//  - Note FSM (states IDLE, PLAY, RELEASE):
//    IDLE:    note_press -> PLAY; note<=keycode, gate<=1, note_on pulse.
//    PLAY:    note_press & keycode==note -> stay. note_press & keycode!=note -> stay, note<=keycode,
//             note_on pulse (retrigger, gate stays 1). ~note_press -> RELEASE, counter<=1.
//    RELEASE: gate stays 1. note_press & keycode==note -> PLAY, counter<=0, no pulse.
//             note_press & keycode!=note -> PLAY, latch, note_on pulse.
//             ~note_press & counter==REL_CYCLES-1 -> IDLE, gate<=0, note_off pulse; else counter+1.
//  - Control key held with a note: note_press=0, so the note enters RELEASE (encoder priority).
//  - note_on and note_off never asserted in the same cycle; each pulse lasts exactly one cycle.
//  - Counter width $clog2(REL_CYCLES+1); never exceeds REL_CYCLES-1.
// STRUCTURE
//  - Package key_ctrl_pkg: typedef enum logic [1:0] {IDLE, PLAY, RELEASE} note_state_t;
//    localparam widths OCT_W=3, MODE_W=2, KEY_W=5.
//  - Sub-module edge_detect #(WIDTH=4): clk, n_rst, in[WIDTH-1:0] -> rise[WIDTH-1:0];
//    one instance for the four control keys. Octave/mode/goof logic and note FSM in top.
// TESTING
//  1 Reset: hold n_rst=0 -> octave=4, mode=0, goof_en=0, gate=0, no pulses; assert n_rst low
//    mid-note -> gate drops asynchronously.
//  2 Octave: 5 separate up presses from 4 -> octave 5,6,7,7,7; 9 down presses -> ends at 0;
//    up held 20 cycles -> exactly +1.
//  3 Mode/goof: 5 mode presses -> mode 1,2,3,0,1; 2 goof presses -> goof_en 1 then 0.
//  4 Note: keycode=9 strobe for 10 cycles -> next cycle gate=1, note=9, note_on 1 cycle; release
//    -> gate stays 1 for REL_CYCLES=16 cycles, then gate=0 with 1-cycle note_off.
//  5 Retrigger/glitch: hold 9, switch to 3 -> note=3, note_on pulse, gate never drops; release 5
//    cycles then repress 3 -> no pulses, gate stays 1.
//  6 Mixed: octave_key_up with strobe while note held -> octave+1, note enters RELEASE, no
//    note_on; keycode=0 note_press -> note=0, gate=1.

Source files
------------

// File: rtl/key_control_pkg.sv
// Shared types and widths for the key_control block.
package key_ctrl_pkg;

   typedef enum logic [1:0] {IDLE, PLAY, RELEASE} note_state_t;

   localparam int OCT_W  = 3;
   localparam int MODE_W = 2;
   localparam int KEY_W  = 5;

   // Bit positions of the control keys inside the edge-detect vector
   localparam int KEY_UP   = 0;
   localparam int KEY_DN   = 1;
   localparam int KEY_MODE = 2;
   localparam int KEY_GOOF = 3;

endpackage

// File: rtl/key_control_if.sv
// Keypad-encoder inputs and synth control outputs of key_control.
interface key_control_if;
   import key_ctrl_pkg::*;

   logic              octave_key_up;
   logic              octave_key_down;
   logic              mode_key;
   logic              goof_key;
   logic [KEY_W-1:0]  keycode;
   logic              strobe;

   logic [OCT_W-1:0]  octave;
   logic [MODE_W-1:0] mode;
   logic              goof_en;
   logic [KEY_W-1:0]  note;
   logic              gate;
   logic              note_on;
   logic              note_off;

   modport master (
      output octave_key_up, octave_key_down, mode_key, goof_key, keycode, strobe,
      input  octave, mode, goof_en, note, gate, note_on, note_off
   );

   modport slave (
      input  octave_key_up, octave_key_down, mode_key, goof_key, keycode, strobe,
      output octave, mode, goof_en, note, gate, note_on, note_off
   );

endinterface

// File: rtl/key_control_edge_detect.sv
// Rising-edge detector: rise is high in the first cycle a bit goes high.
module edge_detect #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] rise
);

   logic [WIDTH-1:0] r_prev;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_prev <= '0;
      end else begin
         r_prev <= in;
      end
   end

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rise
         assign rise[gi] = in[gi] & ~r_prev[gi];
      end
   endgenerate

endmodule

// File: rtl/key_control.sv
// Turns decoded keypad events into octave/mode/goof state and a gated,
// latched note with one-cycle note_on/note_off pulses.
module key_control #(
   parameter int OCT_MAX     = 7,
   parameter int OCT_DEFAULT = 4,
   parameter int NUM_MODES   = 4,
   parameter int REL_CYCLES  = 16
) (
   input  logic          clk,
   input  logic          n_rst,
   key_control_if.slave  kif
);
   import key_ctrl_pkg::*;

   localparam int                CNT_W     = $clog2(REL_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(REL_CYCLES - 1);
   localparam logic [OCT_W-1:0]  OCT_TOP   = OCT_W'(OCT_MAX);
   localparam logic [OCT_W-1:0]  OCT_INIT  = OCT_W'(OCT_DEFAULT);
   localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);

   logic [3:0]        w_keys;
   logic [3:0]        w_rise;
   logic              w_note_press;
   logic              w_same;

   logic [OCT_W-1:0]  r_octave;
   logic [MODE_W-1:0] r_mode;
   logic              r_goof;

   note_state_t       r_state, w_state_next;
   logic [KEY_W-1:0]  r_note, w_note_next;
   logic              r_gate, w_gate_next;
   logic              r_note_on, w_note_on_next;
   logic              r_note_off, w_note_off_next;
   logic [CNT_W-1:0]  r_cnt, w_cnt_next;

   assign w_keys[KEY_UP]   = kif.octave_key_up;
   assign w_keys[KEY_DN]   = kif.octave_key_down;
   assign w_keys[KEY_MODE] = kif.mode_key;
   assign w_keys[KEY_GOOF] = kif.goof_key;

   edge_detect #(.WIDTH(4)) u_edge (
      .clk   (clk),
      .n_rst (n_rst),
      .in    (w_keys),
      .rise  (w_rise)
   );

   // Any control key wins over the note, matching encoder priority
   assign w_note_press = kif.strobe & ~(|w_keys);
   assign w_same       = (kif.keycode == r_note);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_octave <= OCT_INIT;
         r_mode   <= '0;
         r_goof   <= 1'b0;
      end else begin
         if (w_rise[KEY_UP] && !w_rise[KEY_DN]) begin
            if (r_octave != OCT_TOP) r_octave <= r_octave + 1'b1;
         end else if (w_rise[KEY_DN] && !w_rise[KEY_UP]) begin
            if (r_octave != '0) r_octave <= r_octave - 1'b1;
         end
         if (w_rise[KEY_MODE]) begin
            r_mode <= (r_mode == MODE_LAST) ? '0 : r_mode + 1'b1;
         end
         if (w_rise[KEY_GOOF]) begin
            r_goof <= ~r_goof;
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state    <= IDLE;
         r_note     <= '0;
         r_gate     <= 1'b0;
         r_note_on  <= 1'b0;
         r_note_off <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_state    <= w_state_next;
         r_note     <= w_note_next;
         r_gate     <= w_gate_next;
         r_note_on  <= w_note_on_next;
         r_note_off <= w_note_off_next;
         r_cnt      <= w_cnt_next;
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_note_next     = r_note;
      w_gate_next     = r_gate;
      w_note_on_next  = 1'b0;
      w_note_off_next = 1'b0;
      w_cnt_next      = r_cnt;
      unique case (r_state)
         IDLE: begin
            w_gate_next = 1'b0;
            w_cnt_next  = '0;
            if (w_note_press) begin
               w_state_next   = PLAY;
               w_note_next    = kif.keycode;
               w_gate_next    = 1'b1;
               w_note_on_next = 1'b1;
            end
         end
         PLAY: begin
            if (w_note_press) begin
               w_cnt_next = '0;
               if (!w_same) begin
                  w_note_next    = kif.keycode;
                  w_note_on_next = 1'b1;
               end
            end else if (REL_CYCLES == 1) begin
               // A single silent cycle is already the full release window
               w_state_next    = IDLE;
               w_gate_next     = 1'b0;
               w_note_off_next = 1'b1;
               w_cnt_next      = '0;
            end else begin
               w_state_next = RELEASE;
               w_cnt_next   = CNT_W'(1);
            end
         end
         RELEASE: begin
            if (w_note_press) begin
               w_state_next = PLAY;
               w_cnt_next   = '0;
               if (!w_same) begin
                  w_note_next    = kif.keycode;
                  w_note_on_next = 1'b1;
               end
            end else if (r_cnt == CNT_LAST) begin
               w_state_next    = IDLE;
               w_gate_next     = 1'b0;
               w_note_off_next = 1'b1;
               w_cnt_next      = '0;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_next = IDLE;
            w_gate_next  = 1'b0;
            w_cnt_next   = '0;
         end
      endcase
   end

   assign kif.octave   = r_octave;
   assign kif.mode     = r_mode;
   assign kif.goof_en  = r_goof;
   assign kif.note     = r_note;
   assign kif.gate     = r_gate;
   assign kif.note_on  = r_note_on;
   assign kif.note_off = r_note_off;

endmodule
